// File: rtl/cdb_arbiter.sv
// Purpose: round-robin arbiter putting RS/ALU and LSB results onto the single CDB, with one small result queue per producer.
// Latency: 1 cycle from an input on an empty, winning queue (bypass) to the registered broadcast; queued results take 2 or more cycles.
// Backpressure: *_stall asserts combinationally once a queue holds QDEPTH-SLACK entries; a push into a full queue with no pop is dropped and flagged.
module cdb_arbiter #(
    parameter int ROB_IDX_W = 4,
    parameter int DATA_W    = 32,
    parameter int QDEPTH    = 4,
    parameter int SLACK     = 2
) (
    input  logic                 clk,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 roll_back,
    input  logic                 rs_in_en,
    input  logic [ROB_IDX_W-1:0] rs_rob_idx_in,
    input  logic [DATA_W-1:0]    rs_val_in,
    input  logic                 lsb_in_en,
    input  logic [ROB_IDX_W-1:0] lsb_rob_idx_in,
    input  logic [DATA_W-1:0]    lsb_val_in,
    output logic                 rs_stall,
    output logic                 lsb_stall,
    output logic                 cdb_en,
    output logic                 cdb_src,
    output logic [ROB_IDX_W-1:0] cdb_rob_idx,
    output logic [DATA_W-1:0]    cdb_val,
    output logic                 overflow_err
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);
    localparam logic [CW-1:0] STALL_TH = CW'(QDEPTH - SLACK);

    // Source 0 is the RS/ALU writeback, source 1 is the load/store buffer.
    logic [1:0]           in_en;
    logic [ROB_IDX_W-1:0] in_idx [2];
    logic [DATA_W-1:0]    in_val [2];

    assign in_en     = {lsb_in_en, rs_in_en};
    assign in_idx[0] = rs_rob_idx_in;
    assign in_idx[1] = lsb_rob_idx_in;
    assign in_val[0] = rs_val_in;
    assign in_val[1] = lsb_val_in;

    logic [ROB_IDX_W-1:0] q_idx [2][QDEPTH];
    logic [DATA_W-1:0]    q_val [2][QDEPTH];
    logic [PW-1:0]        rd_ptr [2];
    logic [PW-1:0]        wr_ptr [2];
    logic [CW-1:0]        cnt [2];
    logic                 last_grant;

    logic [1:0]           avail, grant, pop, bypass, push_req, full, push, ovf;
    logic [ROB_IDX_W-1:0] cand_idx [2];
    logic [DATA_W-1:0]    cand_val [2];
    logic                 advance;

    // Hold everything while a flush or a global stall is in effect.
    assign advance = !rst_in && !roll_back && rdy_in;

    assign rs_stall  = (cnt[0] >= STALL_TH);
    assign lsb_stall = (cnt[1] >= STALL_TH);

    // Candidate selection, round-robin grant and per-queue push/pop decisions.
    always_comb begin
        avail    = '0;
        grant    = '0;
        pop      = '0;
        bypass   = '0;
        push_req = '0;
        full     = '0;
        push     = '0;
        ovf      = '0;
        for (int s = 0; s < 2; s++) begin
            avail[s]    = (cnt[s] != '0) || in_en[s];
            cand_idx[s] = (cnt[s] != '0) ? q_idx[s][rd_ptr[s]] : in_idx[s];
            cand_val[s] = (cnt[s] != '0) ? q_val[s][rd_ptr[s]] : in_val[s];
        end
        // On a tie the source that did not win last time goes first.
        grant[0] = avail[0] && (!avail[1] || last_grant);
        grant[1] = avail[1] && !grant[0];
        for (int s = 0; s < 2; s++) begin
            pop[s]      = grant[s] && (cnt[s] != '0);
            bypass[s]   = grant[s] && (cnt[s] == '0);
            push_req[s] = in_en[s] && !bypass[s];
            full[s]     = (cnt[s] == FULL_CNT);
            // A full queue that pops this cycle frees the slot being written.
            push[s]     = push_req[s] && (!full[s] || pop[s]);
            ovf[s]      = push_req[s] && full[s] && !pop[s];
        end
    end

    // Queue storage; payload memories need no reset since cnt gates every read.
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    q_idx[s][wr_ptr[s]] <= in_idx[s];
                    q_val[s][wr_ptr[s]] <= in_val[s];
                end
            end
        end
    end

    // Pointers, counts, broadcast registers, grant history and the sticky error.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                cnt[s]    <= '0;
            end
            cdb_en       <= 1'b0;
            cdb_src      <= 1'b0;
            cdb_rob_idx  <= '0;
            cdb_val      <= '0;
            last_grant   <= 1'b1;
            overflow_err <= 1'b0;
        end else if (roll_back) begin
            for (int s = 0; s < 2; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                cnt[s]    <= '0;
            end
            cdb_en      <= 1'b0;
            cdb_src     <= 1'b0;
            cdb_rob_idx <= '0;
            cdb_val     <= '0;
        end else if (rdy_in) begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + PW'(1);
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PW'(1);
                cnt[s] <= cnt[s] + CW'(push[s]) - CW'(pop[s]);
            end
            if (|grant) begin
                cdb_en      <= 1'b1;
                cdb_src     <= grant[1];
                cdb_rob_idx <= grant[1] ? cand_idx[1] : cand_idx[0];
                cdb_val     <= grant[1] ? cand_val[1] : cand_val[0];
                last_grant  <= grant[1];
            end else begin
                cdb_en      <= 1'b0;
                cdb_src     <= 1'b0;
                cdb_rob_idx <= '0;
                cdb_val     <= '0;
            end
            if (|ovf) overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int ROB_IDX_W = 4;
    localparam int DATA_W    = 32;
    localparam int QDEPTH    = 4;
    localparam int SLACK     = 2;

    logic                 clk = 1'b0;
    logic                 rst_in, rdy_in, roll_back;
    logic                 rs_in_en, lsb_in_en;
    logic [ROB_IDX_W-1:0] rs_rob_idx_in, lsb_rob_idx_in;
    logic [DATA_W-1:0]    rs_val_in, lsb_val_in;
    logic                 rs_stall, lsb_stall, cdb_en, cdb_src, overflow_err;
    logic [ROB_IDX_W-1:0] cdb_rob_idx;
    logic [DATA_W-1:0]    cdb_val;

    int vectors = 0;
    int miscompares = 0;

    // Broadcast order for continuous contention (RS 1 / LSB 2, then RS 2k / LSB 2k+1).
    int rr_src [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int rr_idx [10] = '{1, 2, 4, 5, 6, 7, 8, 9, 10, 11};
    // Broadcast order for the overflow scenario; RS idx 10 is the dropped payload.
    int ov_src [14] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
    int ov_idx [14] = '{1, 1, 2, 3, 3, 5, 4, 7, 5, 9, 6, 7, 8, 9};

    always #5 clk = ~clk;

    cdb_arbiter #(
        .ROB_IDX_W(ROB_IDX_W), .DATA_W(DATA_W), .QDEPTH(QDEPTH), .SLACK(SLACK)
    ) dut (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
        .rs_in_en(rs_in_en), .rs_rob_idx_in(rs_rob_idx_in), .rs_val_in(rs_val_in),
        .lsb_in_en(lsb_in_en), .lsb_rob_idx_in(lsb_rob_idx_in), .lsb_val_in(lsb_val_in),
        .rs_stall(rs_stall), .lsb_stall(lsb_stall),
        .cdb_en(cdb_en), .cdb_src(cdb_src), .cdb_rob_idx(cdb_rob_idx), .cdb_val(cdb_val),
        .overflow_err(overflow_err)
    );

    // Payload value derived from source and index so every broadcast is traceable.
    function automatic logic [DATA_W-1:0] pay(input int src, input int idx);
        return (src != 0) ? DATA_W'(32'h2000 + idx) : DATA_W'(32'h1000 + idx);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic re, input int ri, input logic le, input int li);
        rs_in_en       = re;
        rs_rob_idx_in  = ROB_IDX_W'(ri);
        rs_val_in      = pay(0, ri);
        lsb_in_en      = le;
        lsb_rob_idx_in = ROB_IDX_W'(li);
        lsb_val_in     = pay(1, li);
    endtask

    task automatic do_reset;
        rst_in    = 1'b1;
        roll_back = 1'b0;
        rdy_in    = 1'b1;
        drive(1'b0, 0, 1'b0, 0);
        tick;
        tick;
        rst_in = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        vectors++;
        if (cdb_en !== 1'b0 || cdb_src !== 1'b0 || cdb_rob_idx !== '0 || cdb_val !== '0) begin
            miscompares++;
            $display("FAIL reset_cdb: got en=%0b src=%0b idx=%0d val=%h, want all 0",
                     cdb_en, cdb_src, cdb_rob_idx, cdb_val);
        end
        vectors++;
        if (overflow_err !== 1'b0 || rs_stall !== 1'b0 || lsb_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got ovf=%0b rs_stall=%0b lsb_stall=%0b, want 0 0 0",
                     overflow_err, rs_stall, lsb_stall);
        end
    endtask

    task automatic test_bypass;
        do_reset;
        drive(1'b1, 3, 1'b0, 0);
        rs_val_in = 32'h11;
        tick;
        drive(1'b0, 0, 1'b0, 0);
        vectors++;
        if (cdb_en !== 1'b1 || cdb_src !== 1'b0 || cdb_rob_idx !== 4'd3 || cdb_val !== 32'h11) begin
            miscompares++;
            $display("FAIL bypass: got en=%0b src=%0b idx=%0d val=%h, want en=1 src=0 idx=3 val=11",
                     cdb_en, cdb_src, cdb_rob_idx, cdb_val);
        end
        tick;
        vectors++;
        if (cdb_en !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_idle: got en=%0b, want 0", cdb_en);
        end
    endtask

    task automatic test_round_robin;
        do_reset;
        for (int k = 1; k <= 12; k++) begin
            if (k == 1)      drive(1'b1, 1, 1'b1, 2);
            else if (k <= 5) drive(1'b1, 2 * k, 1'b1, 2 * k + 1);
            else             drive(1'b0, 0, 1'b0, 0);
            tick;
            vectors++;
            if (k <= 10) begin
                if (cdb_en !== 1'b1 || cdb_src !== 1'(rr_src[k-1]) ||
                    cdb_rob_idx !== ROB_IDX_W'(rr_idx[k-1]) || cdb_val !== pay(rr_src[k-1], rr_idx[k-1])) begin
                    miscompares++;
                    $display("FAIL rr[%0d]: got en=%0b src=%0b idx=%0d val=%h, want en=1 src=%0d idx=%0d",
                             k, cdb_en, cdb_src, cdb_rob_idx, cdb_val, rr_src[k-1], rr_idx[k-1]);
                end
            end else if (cdb_en !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_drain[%0d]: got en=%0b, want 0", k, cdb_en);
            end
        end
        vectors++;
        if (overflow_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_no_ovf: got %0b, want 0", overflow_err);
        end
    endtask

    task automatic test_stall_threshold;
        logic exp_rs [5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic exp_lsb [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) drive(1'b1, 2 * k, 1'b1, 2 * k + 1);
            else        drive(1'b0, 0, 1'b1, 11);
            tick;
            vectors++;
            if (rs_stall !== exp_rs[k-1] || lsb_stall !== exp_lsb[k-1]) begin
                miscompares++;
                $display("FAIL stall[%0d]: got rs=%0b lsb=%0b, want rs=%0b lsb=%0b",
                         k, rs_stall, lsb_stall, exp_rs[k-1], exp_lsb[k-1]);
            end
        end
    endtask

    task automatic test_overflow;
        do_reset;
        for (int k = 1; k <= 15; k++) begin
            drive(k <= 10, k, (k % 2 == 1) && (k <= 9), k);
            tick;
            vectors++;
            if (k <= 14) begin
                if (cdb_en !== 1'b1 || cdb_src !== 1'(ov_src[k-1]) ||
                    cdb_rob_idx !== ROB_IDX_W'(ov_idx[k-1]) || cdb_val !== pay(ov_src[k-1], ov_idx[k-1])) begin
                    miscompares++;
                    $display("FAIL ovf_seq[%0d]: got en=%0b src=%0b idx=%0d val=%h, want en=1 src=%0d idx=%0d",
                             k, cdb_en, cdb_src, cdb_rob_idx, cdb_val, ov_src[k-1], ov_idx[k-1]);
                end
            end else if (cdb_en !== 1'b0) begin
                miscompares++;
                $display("FAIL ovf_drain: got en=%0b idx=%0d, want en=0", cdb_en, cdb_rob_idx);
            end
            if (k == 8) begin
                vectors++;
                if (rs_stall !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ovf_full_stall: got %0b, want 1", rs_stall);
                end
            end
            if (k == 9 || k == 10) begin
                vectors++;
                if (overflow_err !== (k == 10)) begin
                    miscompares++;
                    $display("FAIL ovf_flag[%0d]: got %0b, want %0b", k, overflow_err, k == 10);
                end
            end
        end
        roll_back = 1'b1;
        tick;
        roll_back = 1'b0;
        vectors++;
        if (overflow_err !== 1'b1 || cdb_en !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_after_rollback: got ovf=%0b en=%0b, want ovf=1 en=0", overflow_err, cdb_en);
        end
        rst_in = 1'b1;
        tick;
        rst_in = 1'b0;
        vectors++;
        if (overflow_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_after_reset: got %0b, want 0", overflow_err);
        end
    endtask

    task automatic test_roll_back;
        do_reset;
        for (int k = 1; k <= 6; k++) begin
            if (k == 1) drive(1'b1, 1, 1'b1, 2);
            else        drive(1'b1, 2 * k, 1'b1, 2 * k + 1);
            tick;
        end
        vectors++;
        if (cdb_en !== 1'b1 || cdb_src !== 1'b1 || cdb_rob_idx !== 4'd7 ||
            rs_stall !== 1'b1 || lsb_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL rb_pre: got en=%0b src=%0b idx=%0d stalls=%0b%0b, want en=1 src=1 idx=7 stalls=11",
                     cdb_en, cdb_src, cdb_rob_idx, rs_stall, lsb_stall);
        end
        roll_back = 1'b1;
        drive(1'b1, 14, 1'b0, 0);
        tick;
        roll_back = 1'b0;
        drive(1'b0, 0, 1'b0, 0);
        vectors++;
        if (cdb_en !== 1'b0 || rs_stall !== 1'b0 || lsb_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL rb_flush: got en=%0b rs_stall=%0b lsb_stall=%0b, want 0 0 0",
                     cdb_en, rs_stall, lsb_stall);
        end
        for (int k = 0; k < 3; k++) begin
            tick;
            vectors++;
            if (cdb_en !== 1'b0) begin
                miscompares++;
                $display("FAIL rb_quiet[%0d]: got en=%0b src=%0b idx=%0d, want en=0", k, cdb_en, cdb_src, cdb_rob_idx);
            end
        end
        drive(1'b1, 15, 1'b0, 0);
        tick;
        vectors++;
        if (cdb_en !== 1'b1 || cdb_src !== 1'b0 || cdb_rob_idx !== 4'd15 || cdb_val !== pay(0, 15)) begin
            miscompares++;
            $display("FAIL rb_new_rs: got en=%0b src=%0b idx=%0d val=%h, want en=1 src=0 idx=15",
                     cdb_en, cdb_src, cdb_rob_idx, cdb_val);
        end
        drive(1'b0, 0, 1'b1, 14);
        tick;
        drive(1'b0, 0, 1'b0, 0);
        vectors++;
        if (cdb_en !== 1'b1 || cdb_src !== 1'b1 || cdb_rob_idx !== 4'd14 || cdb_val !== pay(1, 14)) begin
            miscompares++;
            $display("FAIL rb_new_lsb: got en=%0b src=%0b idx=%0d val=%h, want en=1 src=1 idx=14",
                     cdb_en, cdb_src, cdb_rob_idx, cdb_val);
        end
        tick;
        vectors++;
        if (cdb_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rb_end: got en=%0b idx=%0d, want en=0", cdb_en, cdb_rob_idx);
        end
    endtask

    task automatic test_freeze;
        do_reset;
        for (int k = 1; k <= 5; k++) begin
            if (k == 1) drive(1'b1, 1, 1'b1, 2);
            else        drive(1'b1, 2 * k, 1'b1, 2 * k + 1);
            tick;
        end
        rdy_in = 1'b0;
        drive(1'b1, 13, 1'b1, 12);
        for (int k = 0; k < 3; k++) begin
            tick;
            vectors++;
            if (cdb_en !== 1'b1 || cdb_src !== 1'b0 || cdb_rob_idx !== 4'd6 || cdb_val !== pay(0, 6) ||
                rs_stall !== 1'b1 || lsb_stall !== 1'b1) begin
                miscompares++;
                $display("FAIL freeze_hold[%0d]: got en=%0b src=%0b idx=%0d stalls=%0b%0b, want en=1 src=0 idx=6 stalls=11",
                         k, cdb_en, cdb_src, cdb_rob_idx, rs_stall, lsb_stall);
            end
        end
        rdy_in = 1'b1;
        drive(1'b0, 0, 1'b0, 0);
        for (int k = 6; k <= 11; k++) begin
            tick;
            vectors++;
            if (k <= 10) begin
                if (cdb_en !== 1'b1 || cdb_src !== 1'(rr_src[k-1]) ||
                    cdb_rob_idx !== ROB_IDX_W'(rr_idx[k-1]) || cdb_val !== pay(rr_src[k-1], rr_idx[k-1])) begin
                    miscompares++;
                    $display("FAIL freeze_resume[%0d]: got en=%0b src=%0b idx=%0d, want en=1 src=%0d idx=%0d",
                             k, cdb_en, cdb_src, cdb_rob_idx, rr_src[k-1], rr_idx[k-1]);
                end
            end else if (cdb_en !== 1'b0) begin
                miscompares++;
                $display("FAIL freeze_end: got en=%0b idx=%0d, want en=0", cdb_en, cdb_rob_idx);
            end
        end
    endtask

    initial begin
        test_reset;
        test_bypass;
        test_round_robin;
        test_stall_threshold;
        test_overflow;
        test_roll_back;
        test_freeze;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
